// File: rtl/spi_master_arbiter.sv
// Two-requester round-robin arbiter in front of a shared SPI byte engine.
// Owns the active-low slave selects and applies setup/hold guard times
// around each burst; received bytes are returned to the granted requester.
//
// Ports:
//   clk, rst          system clock, asynchronous active-low reset
//   req_valid/last/data/ready   per-requester byte stream (bit/byte i = requester i)
//   gnt               one-hot current owner, 0 when idle
//   rsp_valid/data    one-cycle pulse with the received byte for the owner
//   core_start/tx     start pulse and transmit byte to the byte engine
//   core_done/rx      completion pulse and received byte from the byte engine
//   ss_n              active-low slave selects, ss_n[i] for requester i
module spi_master_arbiter #(
  parameter int unsigned SS_SETUP = 2,
  parameter int unsigned SS_HOLD  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  input  logic [1:0]  req_last,
  input  logic [15:0] req_data,
  output logic [1:0]  req_ready,
  output logic [1:0]  gnt,
  output logic [1:0]  rsp_valid,
  output logic [7:0]  rsp_data,
  output logic        core_start,
  output logic [7:0]  core_tx,
  input  logic        core_done,
  input  logic [7:0]  core_rx,
  output logic [1:0]  ss_n
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SS_SETUP - 1);
  // Hold runs one cycle past SS_HOLD so select rises SS_HOLD+1 edges after the final done.
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(SS_HOLD);

  typedef enum logic [2:0] {IDLE, SETUP, START, WAIT, HOLD} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             prio_q, prio_d;
  logic             last_q, last_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [1:0]       ss_n_q, ss_n_d;
  logic             core_start_q, core_start_d;
  logic [7:0]       core_tx_q, core_tx_d;
  logic [1:0]       rsp_valid_q, rsp_valid_d;
  logic [7:0]       rsp_data_q, rsp_data_d;

  logic             g_idx;
  logic             win_c;

  // Owner index from the one-hot grant; winner favours prio only on a tie.
  assign g_idx = gnt_q[1];
  assign win_c = (req_valid == 2'b11) ? prio_q : req_valid[1];

  assign req_ready  = (state_q == START) ? gnt_q : 2'b00;
  assign gnt        = gnt_q;
  assign ss_n       = ss_n_q;
  assign core_start = core_start_q;
  assign core_tx    = core_tx_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      prio_q       <= 1'b0;
      last_q       <= 1'b0;
      gnt_q        <= 2'b00;
      ss_n_q       <= 2'b11;
      core_start_q <= 1'b0;
      core_tx_q    <= 8'h00;
      rsp_valid_q  <= 2'b00;
      rsp_data_q   <= 8'h00;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      prio_q       <= prio_d;
      last_q       <= last_d;
      gnt_q        <= gnt_d;
      ss_n_q       <= ss_n_d;
      core_start_q <= core_start_d;
      core_tx_q    <= core_tx_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    prio_d       = prio_q;
    last_d       = last_q;
    gnt_d        = gnt_q;
    ss_n_d       = ss_n_q;
    core_start_d = 1'b0;
    core_tx_d    = core_tx_q;
    rsp_valid_d  = 2'b00;
    rsp_data_d   = rsp_data_q;

    unique case (state_q)
      IDLE: begin
        if (|req_valid) begin
          gnt_d   = 2'b01 << win_c;
          ss_n_d  = ~(2'b01 << win_c);
          cnt_d   = '0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d   = '0;
          state_d = START;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      START: begin
        if (req_valid[g_idx]) begin
          core_tx_d    = g_idx ? req_data[15:8] : req_data[7:0];
          core_start_d = 1'b1;
          last_d       = req_last[g_idx];
          state_d      = WAIT;
        end
      end
      WAIT: begin
        if (core_done) begin
          rsp_data_d  = core_rx;
          rsp_valid_d = gnt_q;
          cnt_d       = '0;
          state_d     = last_q ? HOLD : START;
        end
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          ss_n_d  = 2'b11;
          gnt_d   = 2'b00;
          prio_d  = ~g_idx;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/spi_master_arbiter.md
# spi_master_arbiter

Shares one SPI byte engine (start/done, 8-bit full-duplex) between two requesters and owns the per-slave active-low select lines. Each requester issues a burst of one or more bytes. The arbiter grants the engine round-robin, asserts the matching select with programmable setup and hold guard times, and sequences each byte through the engine. The received byte is returned to the granted requester. The block sits between the system-side SPI clients and the SPI master byte engine.

## Interface
- SS_SETUP, default 2: cycles from select low to the first byte start. Valid range 1..15.
- SS_HOLD, default 2: cycles from last `core_done` to select high. Valid range 1..15.
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  2  per-requester byte-valid; bit i belongs to requester i.
- req_last  in  2  marks the offered byte as the final byte of the burst; qualified by req_valid.
- req_data  in  16  byte for requester i on bits [8i+7:8i].
- req_ready  out  2  byte accepted when req_valid[i] and req_ready[i] are both high.
- gnt  out  2  one-hot current owner; 0 when idle.
- rsp_valid  out  2  one-cycle pulse; received byte available for requester i.
- rsp_data  out  8  received byte, qualified by rsp_valid.
- core_start  out  1  one-cycle start pulse to the byte engine.
- core_tx  out  8  byte to transmit; stable from core_start until core_done.
- core_done  in  1  one-cycle pulse; engine finished and core_rx is valid.
- core_rx  in  8  byte received by the engine.
- ss_n  out  2  active-low slave selects; ss_n[i] serves requester i's slave.

## Operation
- FSM states: IDLE, SETUP, START, WAIT, HOLD.
- **IDLE**: gnt=0, ss_n=2'b11.
  - If any req_valid is high, pick the winner and register gnt and ss_n[winner]=0, then go to SETUP.
  - Round-robin: a 1-bit pointer `prio` names the favoured requester. Reset value is 0.
  - If only one requester is valid, it wins. If both are valid, `prio` wins.
- **SETUP**: count SS_SETUP cycles with a 4-bit counter, then go to START.
- **START**: req_ready[g] = 1 (combinational from state and gnt). req_ready for the non-granted requester is always 0.
  - On accept (req_valid[g] high in START):
    - register core_tx = byte g.
    - pulse core_start the next cycle.
    - latch req_last[g] into `last_q`.
    - go to WAIT.
  - If req_valid[g] stays low, remain in START indefinitely. Select stays low and there is no timeout.
- **WAIT**: on core_done:
  - register rsp_data = core_rx.
  - pulse rsp_valid[g] for one cycle.
  - go to HOLD if last_q is set, otherwise back to START.
- **HOLD**: count SS_HOLD cycles with select still low. Then, on the same edge:
  - ss_n = 2'b11 and gnt = 0.
  - `prio` = the requester that was not granted.
  - go to IDLE.
- core_done outside WAIT is ignored.
- req_valid of the non-granted requester is ignored until IDLE.

## Timing
- All outputs except req_ready are registered.
- Reset values: gnt=0, ss_n=2'b11, core_start=0, core_tx=0, rsp_valid=0, rsp_data=0, req_ready=0, state IDLE, prio=0, counters 0.
- Reset mid-burst: outputs return to their reset values asynchronously, and ss_n deasserts immediately. No rsp_valid is produced for the aborted byte.
- First-byte timing, with req_valid rising before edge E0 in IDLE:
  - gnt and ss_n go low at edge E0.
  - START is entered at E0+SS_SETUP.
  - With req_valid held, the byte is accepted in the first START cycle.
  - core_start is high in the cycle after acceptance.
- Byte turnaround: rsp_valid is high in the cycle after core_done.
  - In that same cycle the FSM is in START, so the next byte can be accepted there.
  - Minimum gap from core_done to the next core_start is 2 cycles.
- Select release: ss_n rises exactly SS_HOLD+1 edges after the edge that samples the final core_done.
  - gnt clears on the same edge.
  - A new grant is possible on the following edge at the earliest (minimum 1 idle cycle with ss_n=2'b11).
- A single-byte burst is a burst with req_last=1 on its first byte.

## Test plan
- Single-byte burst, requester 0 (SS_SETUP=2, SS_HOLD=2): req_data[7:0]=0xA5, last=1; engine returns 0x3C after 8 cycles.
  - Required: ss_n=2'b10, core_start once with core_tx=0xA5, rsp_valid=2'b01 with rsp_data=0x3C, then ss_n=2'b11 exactly 3 edges after core_done.
- Three-byte burst, requester 1 (0x11, 0x22, 0x33, last on 0x33):
  - Required: ss_n[1] low continuously across the burst, three core_start pulses, three rsp_valid[1] pulses in order, and no other requester granted.
- Simultaneous requests from reset, both holding 1-byte bursts:
  - Required: grant order 0 then 1.
  - Repeat both requests: order is again 0 then 1, since prio returns to 0 after requester 1.
  - Then requester 1 alone is granted immediately.
- Stall mid-burst: requester 0 drops req_valid for 20 cycles after byte 1.
  - Required: FSM holds START, ss_n[0] stays 0, no core_start, and the burst resumes on reassertion.
- Async reset asserted in WAIT between core_start and core_done:
  - Required: ss_n=2'b11 and gnt=0 without a clock edge.
  - A late core_done after reset release produces no rsp_valid.
- Spurious core_done in IDLE and SETUP: required no rsp_valid and no state change.
